reg_bank_arbiter: RTL and testbench
===================================

// Module: reg_bank_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one bank of 16-bit sel/wr registers among NREQ masters.
//  Each master posts a single read or write. The block serialises the posts onto the bank's
//  per-register sel, shared wr/wdata and OR-ed rdata, then returns an ack plus read data.
//  It sits between the control masters (CPU bridge, DMA, test port) and the register bank.
// PARAMETERS
//  NREQ  4   number of requesters (2..8)
//  NREG  8   number of registers in the bank (1..2**AW)
//  DW    16  register data width
//  AW    3   register address width
// PORTS
//  clk        in   1         clock, rising edge
//  rstn       in   1         asynchronous active-low reset
//  req        in   NREQ      per-master request; held until its ack
//  req_wr     in   NREQ      1=write, 0=read; stable while req=1
//  req_addr   in   NREQ*AW   register index, master i at [i*AW +: AW]
//  req_wdata  in   NREQ*DW   write data, master i at [i*DW +: DW]
//  ack        out  NREQ      one-cycle completion pulse to the granted master
//  rsp_rdata  out  DW        read data; valid while ack!=0 and the access was a read
//  reg_sel    out  NREG      one-hot register select to the bank
//  reg_wr     out  1         bank write strobe, qualified by reg_sel
//  reg_wdata  out  DW        bank write data
//  reg_rdata  in   NREG*DW   per-register read data (0 when unselected); OR-reduced internally
// BEHAVIOUR
//  - Reset (async, rstn=0): FSM=IDLE; ack, reg_sel, reg_wr, reg_wdata, rsp_rdata all 0.
//    RR pointer = NREQ-1, so master 0 has top priority first. An in-flight access is dropped, not acked.
//  - FSM IDLE -> ACCESS -> DONE -> IDLE:
//    IDLE: if |req, pick the first requester with req=1 scanning ptr+1, ptr+2, ... (mod NREQ).
//          Latch id, wr, addr and wdata; set ptr=id; go to ACCESS. If no req, stay in IDLE.
//    ACCESS: exactly one cycle. reg_sel[addr]=1; reg_wr=latched wr; reg_wdata=latched wdata.
//          On read, capture OR(reg_rdata) into rsp_rdata at the end of the cycle. Go to DONE.
//    DONE: reg_sel=0 and reg_wr=0; ack[id]=1 for this cycle only; go to IDLE.
//  - Outputs are registered. reg_sel/reg_wr are high only in ACCESS.
//    Latency is request sampled in IDLE -> ack 2 cycles later; a transaction takes 3 cycles.
//  - Handshake: a master deasserts req on the clock edge at which it samples its ack=1.
//    req, wr, addr and wdata are ignored outside IDLE, so changes mid-transaction have no effect.
//  - Write: the bank sees sel&wr in ACCESS and loads on that cycle's closing edge.
//    rsp_rdata holds its previous value.
//  - Simultaneous requests: strict rotation. With all masters requesting continuously,
//    grant order is 0,1,2,3,0,... No master waits more than NREQ transactions.
//  - addr >= NREG: no reg_sel bit is set; a read returns 0; the access is still acked.
//  - rsp_rdata holds until the next read capture. Its value is undefined to masters outside ack.
// CONFIGURATION
//  REG_ARB_ERR_EN defined: adds output rsp_err (1 bit, reset 0).
//    rsp_err=1 alongside ack when the latched addr >= NREG; otherwise 0.
//  REG_ARB_ERR_EN undefined: no rsp_err port; out-of-range accesses complete silently as above.
// TESTING
//  1. Reset: rstn=0 mid-ACCESS -> reg_sel=0, ack=0 immediately; after release the FSM is IDLE
//     and the next grant goes to master 0.
//  2. Single write: m1 write addr=2 wdata=16'hA5A5 -> reg_sel=8'h04, reg_wr=1 for one cycle;
//     ack=4'b0010 two cycles after req is sampled; a bank readback gives 16'hA5A5.
//  3. Single read: bank reg5=16'h1234, m3 reads addr=5 -> reg_sel=8'h20, reg_wr=0;
//     ack=4'b1000 with rsp_rdata=16'h1234.
//  4. Fairness: all 4 masters request continuously -> ack order 0,1,2,3,0,1 with one ack every 3 cycles.
//     Then only m2 requests -> m2 is granted immediately.
//  5. Out-of-range: NREG=6, m0 reads addr=7 -> reg_sel=0, rsp_rdata=0, ack=4'b0001;
//     with REG_ARB_ERR_EN, rsp_err=1 in the ack cycle.
//  6. Mid-transaction change: m0 flips req_wr/req_addr during ACCESS -> the bank sees the
//     originally latched values.

Source files
------------

// File: rtl/reg_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_arbiter
// Purpose  : Round-robin arbiter/sequencer that shares one bank of registers
//            among NREQ control masters. Each master posts a single read or
//            write. The block serialises the posts onto the bank's per-register
//            select, shared write strobe/data and OR-ed read data, then returns
//            a one-cycle ack (plus read data) to the granted master.
// Ports    : clk        - clock, rising edge
//            rstn       - asynchronous active-low reset
//            req        - per-master request, held until its ack
//            req_wr     - per-master 1=write / 0=read
//            req_addr   - per-master register index, master i at [i*AW +: AW]
//            req_wdata  - per-master write data, master i at [i*DW +: DW]
//            ack        - one-cycle completion pulse to the granted master
//            rsp_rdata  - read data, meaningful while ack!=0 on a read
//            reg_sel    - one-hot register select to the bank
//            reg_wr     - bank write strobe, qualified by reg_sel
//            reg_wdata  - bank write data
//            reg_rdata  - per-register read data (0 when unselected)
//            rsp_err    - only with REG_ARB_ERR_EN: out-of-range flag with ack
// Options  : REG_ARB_ERR_EN - when defined, adds the rsp_err output.
// Revision : 1.0 - initial release
// ============================================================================
module reg_bank_arbiter #(
  parameter int NREQ = 4,
  parameter int NREG = 8,
  parameter int DW   = 16,
  parameter int AW   = 3
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_wr,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      ack,
  output logic [DW-1:0]        rsp_rdata,
  output logic [NREG-1:0]      reg_sel,
  output logic                 reg_wr,
  output logic [DW-1:0]        reg_wdata,
  input  logic [NREG*DW-1:0]   reg_rdata
`ifdef REG_ARB_ERR_EN
  ,
  output logic                 rsp_err
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_ACCESS = 2'd1;
  localparam logic [1:0] c_DONE   = 2'd2;

  logic [1:0]      r_state;
  logic [PW-1:0]   r_ptr;    // last granted master; search starts at r_ptr+1
  logic [PW-1:0]   r_id;
  logic            r_wr;
  logic [AW-1:0]   r_addr;

  logic            w_found;
  logic [PW-1:0]   w_gnt;
  logic            w_gnt_wr;
  logic [AW-1:0]   w_gnt_addr;
  logic [DW-1:0]   w_gnt_wdata;
  logic [NREG-1:0] w_sel_dec;
  logic [NREQ-1:0] w_ack_dec;
  logic [DW-1:0]   w_rdata_or;
  logic            w_oor;

  // Rotating priority: scan ptr+1, ptr+2, ... wrapping, first active req wins.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_found && req[(int'(r_ptr) + k) % NREQ]) begin
        w_found = 1'b1;
        w_gnt   = PW'((int'(r_ptr) + k) % NREQ);
      end
    end
  end

  assign w_gnt_wr    = req_wr[w_gnt];
  assign w_gnt_addr  = req_addr[int'(w_gnt)*AW +: AW];
  assign w_gnt_wdata = req_wdata[int'(w_gnt)*DW +: DW];

  // Addresses at or beyond NREG decode to no select bit at all.
  for (genvar r = 0; r < NREG; r++) begin : g_sel
    assign w_sel_dec[r] = (int'(w_gnt_addr) == r);
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_ack
    assign w_ack_dec[i] = (int'(r_id) == i);
  end

  always_comb begin
    w_rdata_or = '0;
    for (int r = 0; r < NREG; r++) begin
      w_rdata_or = w_rdata_or | reg_rdata[r*DW +: DW];
    end
  end

  assign w_oor = (int'(r_addr) >= NREG);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= c_IDLE;
      r_ptr     <= PW'(NREQ - 1);
      r_id      <= '0;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      ack       <= '0;
      rsp_rdata <= '0;
      reg_sel   <= '0;
      reg_wr    <= 1'b0;
      reg_wdata <= '0;
`ifdef REG_ARB_ERR_EN
      rsp_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_found) begin
            r_state   <= c_ACCESS;
            r_ptr     <= w_gnt;
            r_id      <= w_gnt;
            r_wr      <= w_gnt_wr;
            r_addr    <= w_gnt_addr;
            // Bank-facing outputs are loaded here so they are live for
            // exactly the ACCESS cycle.
            reg_sel   <= w_sel_dec;
            reg_wr    <= w_gnt_wr;
            reg_wdata <= w_gnt_wdata;
          end
        end
        c_ACCESS: begin
          reg_sel <= '0;
          reg_wr  <= 1'b0;
          if (!r_wr) begin
            rsp_rdata <= w_oor ? '0 : w_rdata_or;
          end
          ack     <= w_ack_dec;
`ifdef REG_ARB_ERR_EN
          rsp_err <= w_oor;
`endif
          r_state <= c_DONE;
        end
        c_DONE: begin
          ack     <= '0;
`ifdef REG_ARB_ERR_EN
          rsp_err <= 1'b0;
`endif
          r_state <= c_IDLE;
        end
        default: begin
          ack     <= '0;
          reg_sel <= '0;
          reg_wr  <= 1'b0;
`ifdef REG_ARB_ERR_EN
          rsp_err <= 1'b0;
`endif
          r_state <= c_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_bank_arbiter
// Purpose  : Self-checking bench for reg_bank_arbiter with a behavioural
//            register bank. Expected acks and bank accesses are queued by the
//            stimulus and checked by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_bank_arbiter;

  localparam int NREQ = 4;
  localparam int NREG = 6;
  localparam int DW   = 16;
  localparam int AW   = 3;

  logic                clk = 1'b0;
  logic                rstn;
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     req_wr;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_wdata;
  logic [NREQ-1:0]     ack;
  logic [DW-1:0]       rsp_rdata;
  logic [NREG-1:0]     reg_sel;
  logic                reg_wr;
  logic [DW-1:0]       reg_wdata;
  logic [NREG*DW-1:0]  reg_rdata;
`ifdef REG_ARB_ERR_EN
  logic                rsp_err;
`endif

  reg_bank_arbiter #(.NREQ(NREQ), .NREG(NREG), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ack       (ack),
    .rsp_rdata (rsp_rdata),
    .reg_sel   (reg_sel),
    .reg_wr    (reg_wr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata)
`ifdef REG_ARB_ERR_EN
    ,
    .rsp_err   (rsp_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural register bank.
  logic [DW-1:0] bank [NREG];
  always @(posedge clk) begin
    if (reg_wr) begin
      for (int r = 0; r < NREG; r++) begin
        if (reg_sel[r]) bank[r] <= reg_wdata;
      end
    end
  end
  always_comb begin
    reg_rdata = '0;
    for (int r = 0; r < NREG; r++) begin
      if (reg_sel[r]) reg_rdata[r*DW +: DW] = bank[r];
    end
  end

  typedef struct {
    int          id;
    bit          rd;
    logic [15:0] rdata;
    bit          err;
    int          cyc;
  } ack_t;

  typedef struct {
    logic [NREG-1:0] sel;
    bit              wr;
    logic [15:0]     wdata;
    int              cyc;
  } acc_t;

  ack_t exp_ack[$];
  acc_t exp_acc[$];

  int checks = 0;
  int errors = 0;
  int repost [NREQ];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_ack(input int id, input bit rd, input logic [15:0] rdata,
                            input bit err, input int c);
    ack_t e;
    e.id = id; e.rd = rd; e.rdata = rdata; e.err = err; e.cyc = c;
    exp_ack.push_back(e);
  endtask

  task automatic expect_acc(input int addr, input bit wr, input logic [15:0] wd, input int c);
    acc_t a;
    a.sel = NREG'(1) << addr; a.wr = wr; a.wdata = wd; a.cyc = c;
    exp_acc.push_back(a);
  endtask

  task automatic post(input int m, input bit wr, input int addr, input logic [15:0] wd);
    req_wr[m]              = wr;
    req_addr[m*AW +: AW]   = AW'(addr);
    req_wdata[m*DW +: DW]  = wd;
    req[m]                 = 1'b1;
  endtask

  // Advance to the next falling edge; masters drop req once they see ack
  // unless they have further back-to-back posts queued.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (ack[i]) begin
        if (repost[i] > 0) repost[i] = repost[i] - 1;
        else req[i] = 1'b0;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (n < 60 && (exp_ack.size() != 0 || exp_acc.size() != 0 || req != '0)) begin
      tick();
      n++;
    end
    chk("drain_pending", exp_ack.size() + exp_acc.size(), 0);
    tick();
    tick();
  endtask

  // Monitor / scoreboard
  initial begin : mon
    ack_t e;
    acc_t a;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (ack != '0) begin
          if (exp_ack.size() == 0) begin
            chk("unexpected_ack", 32'(ack), 0);
          end else begin
            e = exp_ack.pop_front();
            chk("ack_vector", 32'(ack), 32'(1) << e.id);
            chk("ack_cycle", cyc, e.cyc);
            if (e.rd) chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
`ifdef REG_ARB_ERR_EN
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
`endif
          end
        end
        if (reg_sel != '0 || reg_wr) begin
          if (exp_acc.size() == 0) begin
            chk("unexpected_access", 32'(reg_sel), 0);
          end else begin
            a = exp_acc.pop_front();
            chk("reg_sel", 32'(reg_sel), 32'(a.sel));
            chk("reg_wr", 32'(reg_wr), 32'(a.wr));
            chk("reg_wdata", 32'(reg_wdata), 32'(a.wdata));
            chk("access_cycle", cyc, a.cyc);
          end
        end
      end
    end
  end

  initial begin : stim
    int c;
    req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < NREQ; i++) repost[i] = 0;
    rstn = 1'b0;
    #1;
    chk("rst_ack", 32'(ack), 0);
    chk("rst_reg_sel", 32'(reg_sel), 0);
    chk("rst_reg_wr", 32'(reg_wr), 0);
    chk("rst_reg_wdata", 32'(reg_wdata), 0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
`ifdef REG_ARB_ERR_EN
    chk("rst_rsp_err", 32'(rsp_err), 0);
`endif
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    tick();

    // Single write: m1 -> reg2
    c = cyc;
    post(1, 1'b1, 2, 16'hA5A5);
    expect_acc(2, 1'b1, 16'hA5A5, c + 1);
    expect_ack(1, 1'b0, 16'h0, 1'b0, c + 2);
    drain();

    // Preload reg5 via m2, then single read by m3
    c = cyc;
    post(2, 1'b1, 5, 16'h1234);
    expect_acc(5, 1'b1, 16'h1234, c + 1);
    expect_ack(2, 1'b0, 16'h0, 1'b0, c + 2);
    drain();
    c = cyc;
    post(3, 1'b0, 5, 16'h0000);
    expect_acc(5, 1'b0, 16'h0000, c + 1);
    expect_ack(3, 1'b1, 16'h1234, 1'b0, c + 2);
    drain();

    // Reset in the middle of an ACCESS cycle: dropped, never acked
    post(2, 1'b0, 1, 16'h0000);
    @(posedge clk);
    #1;
    chk("pre_reset_sel", 32'(reg_sel), 32'h02);
    #1;
    rstn = 1'b0;
    #1;
    chk("midrst_reg_sel", 32'(reg_sel), 0);
    chk("midrst_ack", 32'(ack), 0);
    chk("midrst_reg_wr", 32'(reg_wr), 0);
    req = '0;
    tick();
    rstn = 1'b1;
    tick();

    // Fairness: all masters request; m0 and m1 post twice back-to-back
    c = cyc;
    repost[0] = 1;
    repost[1] = 1;
    post(0, 1'b1, 0, 16'h1000);
    post(1, 1'b1, 1, 16'h1001);
    post(2, 1'b1, 3, 16'h1003);
    post(3, 1'b1, 4, 16'h1004);
    expect_acc(0, 1'b1, 16'h1000, c + 1);  expect_ack(0, 1'b0, 16'h0, 1'b0, c + 2);
    expect_acc(1, 1'b1, 16'h1001, c + 4);  expect_ack(1, 1'b0, 16'h0, 1'b0, c + 5);
    expect_acc(3, 1'b1, 16'h1003, c + 7);  expect_ack(2, 1'b0, 16'h0, 1'b0, c + 8);
    expect_acc(4, 1'b1, 16'h1004, c + 10); expect_ack(3, 1'b0, 16'h0, 1'b0, c + 11);
    expect_acc(0, 1'b1, 16'h1000, c + 13); expect_ack(0, 1'b0, 16'h0, 1'b0, c + 14);
    expect_acc(1, 1'b1, 16'h1001, c + 16); expect_ack(1, 1'b0, 16'h0, 1'b0, c + 17);
    drain();

    // Only m2 requests: granted straight away; reads back the earlier write
    c = cyc;
    post(2, 1'b0, 2, 16'h0000);
    expect_acc(2, 1'b0, 16'h0000, c + 1);
    expect_ack(2, 1'b1, 16'hA5A5, 1'b0, c + 2);
    drain();

    // Out-of-range read: no select, data 0, still acked
    c = cyc;
    post(0, 1'b0, 7, 16'h0000);
    expect_ack(0, 1'b1, 16'h0000, 1'b1, c + 2);
    drain();

    // Mid-transaction change: m0 alters its request during ACCESS
    c = cyc;
    post(0, 1'b1, 4, 16'h1111);
    expect_acc(4, 1'b1, 16'h1111, c + 1);
    expect_ack(0, 1'b0, 16'h0, 1'b0, c + 2);
    tick();
    req_wr[0]           = 1'b0;
    req_addr[0 +: AW]   = AW'(1);
    req_wdata[0 +: DW]  = 16'hFFFF;
    drain();

    c = cyc;
    post(1, 1'b0, 4, 16'h0000);
    expect_acc(4, 1'b0, 16'h0000, c + 1);
    expect_ack(1, 1'b1, 16'h1111, 1'b0, c + 2);
    drain();
    c = cyc;
    post(3, 1'b0, 1, 16'h0000);
    expect_acc(1, 1'b0, 16'h0000, c + 1);
    expect_ack(3, 1'b1, 16'h1001, 1'b0, c + 2);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
